// File: rtl/topology_sequencer_if.sv
// Bus bundle between topology_sequencer, its topology BRAM and the layer engine.
interface topology_sequencer_if #(
  parameter int unsigned ADDR_LEN = 2,
  parameter int unsigned DATA_LEN = 16
);
  logic                start_i;
  logic                topo_ena_o;
  logic [ADDR_LEN-1:0] topo_addr_o;
  logic [DATA_LEN-1:0] topo_data_i;
  logic                layer_valid_o;
  logic                layer_ready_i;
  logic [ADDR_LEN-1:0] layer_idx_o;
  logic [DATA_LEN-1:0] in_count_o;
  logic [DATA_LEN-1:0] out_count_o;
  logic                busy_o;
  logic                done_o;
  logic                error_o;

  modport master (
    input  start_i, topo_data_i, layer_ready_i,
    output topo_ena_o, topo_addr_o, layer_valid_o, layer_idx_o,
           in_count_o, out_count_o, busy_o, done_o, error_o
  );

  modport slave (
    output start_i, topo_data_i, layer_ready_i,
    input  topo_ena_o, topo_addr_o, layer_valid_o, layer_idx_o,
           in_count_o, out_count_o, busy_o, done_o, error_o
  );
endinterface

// File: rtl/topology_sequencer.sv
// Walks the topology BRAM table and emits one (idx, in, out) descriptor per layer.
// Optional table validation is enabled by defining TOPO_CHECK_EN.
module topology_sequencer #(
  parameter int unsigned ADDR_LEN = 2,
  parameter int unsigned DATA_LEN = 16
) (
  input logic                  clk_i,
  input logic                  reset_i,
  topology_sequencer_if.master bus
);

  typedef enum logic [2:0] {IDLE, REQ, CAP, ISSUE, DONE} state_t;

`ifdef TOPO_CHECK_EN
  localparam logic [DATA_LEN-1:0] MIN_L = DATA_LEN'(2);
  localparam logic [DATA_LEN-1:0] MAX_L = DATA_LEN'((1 << ADDR_LEN) - 1);
`endif

  state_t              state_q, state_d;
  logic [ADDR_LEN-1:0] w_q, w_d, k_q, k_d, len_q, len_d, addr_q, addr_d;
  logic [DATA_LEN-1:0] prev_q, prev_d, in_q, in_d, out_q, out_d;
  logic                err_q, err_d;
  logic                ena_q, ena_d, valid_q, valid_d, busy_q, busy_d, done_q, done_d;

  // State and every output register
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= IDLE;
      w_q     <= '0;
      k_q     <= '0;
      len_q   <= '0;
      prev_q  <= '0;
      in_q    <= '0;
      out_q   <= '0;
      err_q   <= 1'b0;
      ena_q   <= 1'b0;
      addr_q  <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      w_q     <= w_d;
      k_q     <= k_d;
      len_q   <= len_d;
      prev_q  <= prev_d;
      in_q    <= in_d;
      out_q   <= out_d;
      err_q   <= err_d;
      ena_q   <= ena_d;
      addr_q  <= addr_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next state and table-walk datapath
  always_comb begin
    state_d = state_q;
    w_d     = w_q;
    k_d     = k_q;
    len_d   = len_q;
    prev_d  = prev_q;
    in_d    = in_q;
    out_d   = out_q;
    err_d   = err_q;
    unique case (state_q)
      IDLE: begin
        if (bus.start_i) begin
          w_d     = '0;
          k_d     = '0;
          err_d   = 1'b0;
          state_d = REQ;
        end
      end
      REQ: state_d = CAP;
      CAP: begin
        if (w_q == '0) begin
`ifdef TOPO_CHECK_EN
          if (bus.topo_data_i < MIN_L || bus.topo_data_i > MAX_L) begin
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            len_d   = bus.topo_data_i[ADDR_LEN-1:0];
            w_d     = ADDR_LEN'(1);
            state_d = REQ;
          end
`else
          // Out-of-range headers still terminate: mask, then floor at 2
          len_d   = (bus.topo_data_i[ADDR_LEN-1:0] < ADDR_LEN'(2)) ?
                    ADDR_LEN'(2) : bus.topo_data_i[ADDR_LEN-1:0];
          w_d     = ADDR_LEN'(1);
          state_d = REQ;
`endif
        end
`ifdef TOPO_CHECK_EN
        else if (bus.topo_data_i == '0) begin
          err_d   = 1'b1;
          state_d = DONE;
        end
`endif
        else if (w_q == ADDR_LEN'(1)) begin
          prev_d  = bus.topo_data_i;
          w_d     = ADDR_LEN'(2);
          state_d = REQ;
        end else begin
          out_d   = bus.topo_data_i;
          in_d    = prev_q;
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.layer_ready_i) begin
          prev_d  = out_q;
          k_d     = k_q + ADDR_LEN'(1);
          w_d     = w_q + ADDR_LEN'(1);
          state_d = (w_q == len_q) ? DONE : REQ;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Registered-output next values, aligned with the state they belong to
  always_comb begin
    ena_d   = 1'b0;
    addr_d  = addr_q;
    valid_d = 1'b0;
    busy_d  = (state_d != IDLE);
    done_d  = (state_d == DONE);
    if (state_d == REQ) begin
      ena_d  = 1'b1;
      addr_d = w_d;
    end
    if (state_d == ISSUE) valid_d = 1'b1;
  end

  assign bus.topo_ena_o    = ena_q;
  assign bus.topo_addr_o   = addr_q;
  assign bus.layer_valid_o = valid_q;
  assign bus.layer_idx_o   = k_q;
  assign bus.in_count_o    = in_q;
  assign bus.out_count_o   = out_q;
  assign bus.busy_o        = busy_q;
  assign bus.done_o        = done_q;
  assign bus.error_o       = err_q;

endmodule

// File: tb/tb_topology_sequencer.sv
// Directed self-checking bench for topology_sequencer with a behavioural BRAM.
module tb_topology_sequencer;

  logic        clk;
  logic        reset;
  logic [15:0] mem [0:3];

  int n_checks = 0;
  int n_pass   = 0;

  int          n_desc, done_cyc, idle_cyc, done_cnt, stall_cnt, hold_bad;
  int          max_addr, err_seen, err_c1, rst_ok;
  int          d_cyc [0:3];
  logic [63:0] d_val [0:3];

  topology_sequencer_if #(.ADDR_LEN(2), .DATA_LEN(16)) bus ();

  topology_sequencer #(.ADDR_LEN(2), .DATA_LEN(16)) dut (
    .clk_i   (clk),
    .reset_i (reset),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One-cycle-latency BRAM
  always @(posedge clk) if (bus.topo_ena_o) bus.topo_data_i <= mem[bus.topo_addr_o];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [63:0] dv(input int i, input int a, input int b);
    return {30'd0, 2'(i), 16'(a), 16'(b)};
  endfunction

  function automatic logic [63:0] cur_desc();
    return {30'd0, bus.layer_idx_o, bus.in_count_o, bus.out_count_o};
  endfunction

  function automatic logic [63:0] all_outs();
    return {24'd0, bus.topo_ena_o, bus.topo_addr_o, bus.layer_valid_o, bus.layer_idx_o,
            bus.in_count_o, bus.out_count_o, bus.busy_o, bus.done_o, bus.error_o};
  endfunction

  task automatic set_table(input int a, input int b, input int c, input int d);
    mem[0] = 16'(a); mem[1] = 16'(b); mem[2] = 16'(c); mem[3] = 16'(d);
  endtask

  // Entered at #1 after an edge; start is sampled on the next edge (edge 0).
  task automatic run_walk(input int stall_from, input int stall_len,
                          input int restart_at, input int reset_at);
    logic [63:0] held;
    bit          holding;
    n_desc = 0; done_cyc = 0; idle_cyc = 0; done_cnt = 0; stall_cnt = 0; hold_bad = 0;
    max_addr = 0; err_seen = 0; err_c1 = 0; rst_ok = 0; holding = 0; held = '0;
    bus.layer_ready_i = 1'b1;
    bus.start_i = 1'b1;
    @(posedge clk); #1;
    bus.start_i = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      if (reset_at > 0 && c == reset_at + 1) begin
        rst_ok = (all_outs() == 64'd0) ? 1 : 0;
        reset = 1'b0;
        break;
      end
      bus.layer_ready_i = !(c >= stall_from && c < stall_from + stall_len);
      bus.start_i = (c == restart_at);
      if (reset_at > 0 && c == reset_at) reset = 1'b1;
      if (c == 1) err_c1 = int'(bus.error_o);
      if (bus.error_o) err_seen = 1;
      if (bus.topo_ena_o && int'(bus.topo_addr_o) > max_addr) max_addr = int'(bus.topo_addr_o);
      if (bus.done_o) begin done_cnt++; done_cyc = c; end
      if (bus.layer_valid_o) begin
        if (holding && cur_desc() != held) hold_bad++;
        held = cur_desc();
        holding = 1;
        if (bus.layer_ready_i) begin
          if (n_desc < 4) begin d_cyc[n_desc] = c; d_val[n_desc] = held; end
          n_desc++;
          holding = 0;
        end else stall_cnt++;
      end
      if (done_cnt > 0 && !bus.busy_o) begin idle_cyc = c; break; end
      @(posedge clk); #1;
    end
    bus.start_i = 1'b0;
    bus.layer_ready_i = 1'b1;
  endtask

  initial begin
    int quiet_bad;
    reset = 1'b1;
    bus.start_i = 1'b0;
    bus.layer_ready_i = 1'b0;
    bus.topo_data_i = '0;
    set_table(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", all_outs(), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_after_reset", all_outs(), 64'd0);

    // Basic walk, ready tied high
    set_table(3, 4, 3, 2);
    run_walk(0, 0, 0, 0);
    check("s1_ndesc", 64'(n_desc), 64'd2);
    check("s1_d0_cyc", 64'(d_cyc[0]), 64'd7);
    check("s1_d0", d_val[0], dv(0, 4, 3));
    check("s1_d1_cyc", 64'(d_cyc[1]), 64'd10);
    check("s1_d1", d_val[1], dv(1, 3, 2));
    check("s1_done_cyc", 64'(done_cyc), 64'd11);
    check("s1_done_cnt", 64'(done_cnt), 64'd1);
    check("s1_idle_cyc", 64'(idle_cyc), 64'd12);
    check("s1_max_addr", 64'(max_addr), 64'd3);
    check("s1_error", 64'(err_seen), 64'd0);

    // Backpressure on first ISSUE for 5 cycles
    run_walk(7, 5, 0, 0);
    check("s2_stall_cnt", 64'(stall_cnt), 64'd5);
    check("s2_hold_bad", 64'(hold_bad), 64'd0);
    check("s2_d0_cyc", 64'(d_cyc[0]), 64'd12);
    check("s2_d0", d_val[0], dv(0, 4, 3));
    check("s2_d1_cyc", 64'(d_cyc[1]), 64'd15);
    check("s2_d1", d_val[1], dv(1, 3, 2));
    check("s2_done_cyc", 64'(done_cyc), 64'd16);
    check("s2_idle_cyc", 64'(idle_cyc), 64'd17);

    // Minimal two-size table
    set_table(2, 8, 1, 16'hbeef);
    run_walk(0, 0, 0, 0);
    check("s3_ndesc", 64'(n_desc), 64'd1);
    check("s3_d0_cyc", 64'(d_cyc[0]), 64'd7);
    check("s3_d0", d_val[0], dv(0, 8, 1));
    check("s3_done_cyc", 64'(done_cyc), 64'd8);
    check("s3_idle_cyc", 64'(idle_cyc), 64'd9);
    check("s3_max_addr", 64'(max_addr), 64'd2);

    // start pulsed while busy is ignored
    set_table(3, 4, 3, 2);
    run_walk(0, 0, 4, 0);
    check("s4_ndesc", 64'(n_desc), 64'd2);
    check("s4_d1", d_val[1], dv(1, 3, 2));
    check("s4_done_cnt", 64'(done_cnt), 64'd1);
    check("s4_idle_cyc", 64'(idle_cyc), 64'd12);
    @(posedge clk); #1;
    check("s4_stays_idle", 64'(bus.busy_o), 64'd0);

    // Reset during second ISSUE handshake
    run_walk(0, 0, 0, 10);
    check("s5_reset_zero", 64'(rst_ok), 64'd1);
    quiet_bad = 0;
    for (int i = 0; i < 10; i++) begin
      if (bus.layer_valid_o || bus.busy_o) quiet_bad++;
      @(posedge clk); #1;
    end
    check("s5_quiet", 64'(quiet_bad), 64'd0);
    run_walk(0, 0, 0, 0);
    check("s5_replay_ndesc", 64'(n_desc), 64'd2);
    check("s5_replay_d0", d_val[0], dv(0, 4, 3));
    check("s5_replay_d0_cyc", 64'(d_cyc[0]), 64'd7);
    check("s5_replay_idle", 64'(idle_cyc), 64'd12);

`ifdef TOPO_CHECK_EN
    // Zero size word
    set_table(3, 4, 0, 2);
    run_walk(0, 0, 0, 0);
    check("e1_ndesc", 64'(n_desc), 64'd0);
    check("e1_error", 64'(err_seen), 64'd1);
    check("e1_done_cnt", 64'(done_cnt), 64'd1);
    check("e1_done_cyc", 64'(done_cyc), 64'd7);
    check("e1_sticky", 64'(bus.error_o), 64'd1);
    // Header below range
    set_table(1, 4, 3, 2);
    run_walk(0, 0, 0, 0);
    check("e2_ndesc", 64'(n_desc), 64'd0);
    check("e2_done_cyc", 64'(done_cyc), 64'd3);
    check("e2_error", 64'(bus.error_o), 64'd1);
    // Good table clears the flag
    set_table(3, 4, 3, 2);
    run_walk(0, 0, 0, 0);
    check("e3_err_cleared", 64'(err_c1), 64'd0);
    check("e3_ndesc", 64'(n_desc), 64'd2);
    check("e3_error_end", 64'(bus.error_o), 64'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/topology_sequencer.md
# topology_sequencer

Reads the network topology table out of the single-port topology BRAM and turns it into a sequence of per-layer work descriptors (layer index, input width, output width) for the downstream layer compute engine. It sits between the topology BRAM and the layer engine. It owns the BRAM's enable/address lines and hands descriptors forward over a valid/ready handshake, one layer at a time.

## Interface
Parameters:
- ADDR_LEN, 2, topology BRAM address width; the table holds 2**ADDR_LEN words
- DATA_LEN, 16, topology BRAM word width and descriptor count width

Ports (one clock; reset is synchronous and active-high):
- clk_i  in  1  clock; all state updates on the rising edge
- reset_i  in  1  synchronous, active-high reset
- start_i  in  1  single-cycle request to walk the table; sampled only in IDLE
- topo_ena_o  out  1  BRAM enable
- topo_addr_o  out  ADDR_LEN  BRAM read address
- topo_data_i  in  DATA_LEN  BRAM read data; valid the cycle after topo_ena_o=1 with topo_addr_o
- layer_valid_o  out  1  descriptor valid
- layer_ready_i  in  1  downstream engine accepts the descriptor
- layer_idx_o  out  ADDR_LEN  layer number, starting at 0
- in_count_o  out  DATA_LEN  neurons feeding this layer
- out_count_o  out  DATA_LEN  neurons in this layer
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse after the last descriptor is accepted
- error_o  out  1  sticky malformed-table flag; cleared by reset or by the next accepted start_i

## Operation
- Table format: word 0 = L, the number of sizes. Words 1..L = neuron count per level. The walk emits L-1 descriptors; descriptor k carries (size[k], size[k+1]).
- States: IDLE, REQ, CAP, ISSUE, DONE. Every output is registered.
- IDLE: when start_i=1, clear the word index w to 0 and the layer index k to 0, then go to REQ.
- REQ: drive topo_ena_o=1 and topo_addr_o=w, then go to CAP. topo_ena_o=0 in every other state.
- CAP: capture topo_data_i.
  - If w=0: L ← data, w ← 1, go to REQ.
  - If w=1: prev ← data, w ← 2, go to REQ.
  - If w≥2: out_count ← data, in_count ← prev, go to ISSUE.
- ISSUE: layer_valid_o=1. Descriptor fields stay stable until the cycle where layer_valid_o=1 and layer_ready_i=1. On that handshake:
  - prev ← out_count, k ← k+1, w ← w+1.
  - If w = L, go to DONE; otherwise go to REQ.
- DONE: done_o=1 for exactly one cycle, then go to IDLE.
- Address arithmetic is ADDR_LEN bits wide. The legal L range 2..2**ADDR_LEN-1 guarantees w never wraps.
- start_i is ignored while busy_o=1.
- layer_ready_i held high before valid has no effect; a transfer needs both signals high.
- Reset values: topo_ena_o=0, topo_addr_o=0, layer_valid_o=0, layer_idx_o=0, in_count_o=0, out_count_o=0, busy_o=0, done_o=0, error_o=0, state=IDLE.
- A reset asserted mid-walk (including mid-handshake) returns every output to its reset value on the next edge. No descriptor is emitted afterwards.

## Timing
- start_i sampled high at edge 0:
  - header REQ at cycle 1, CAP at 2
  - size0 REQ at 3, CAP at 4
  - size1 REQ at 5, CAP at 6
  - first layer_valid_o=1 at cycle 7
- Descriptor-to-descriptor with ready tied high: handshake at cycle n, REQ at n+1, CAP at n+2, next valid at n+3.
- Last handshake at cycle n: done_o=1 at n+1, busy_o=0 and IDLE at n+2.
- Backpressure: each cycle with layer_ready_i=0 in ISSUE adds one cycle to the schedule.

## Configuration
- Macro TOPO_CHECK_EN defined: in CAP for w=0, L<2 or L>2**ADDR_LEN-1 sets error_o=1 and goes to DONE. A size word equal to 0 does the same. No descriptor is issued after an error, and done_o still pulses once.
- Macro TOPO_CHECK_EN undefined: no checks are made and error_o is tied to 0.
  - Malformed tables give undefined descriptor contents.
  - The state machine must still reach DONE, using L masked to the ADDR_LEN range with a floor of 2.

## Test plan
- Table {3,4,3,2}, ready high, start at edge 0 -> descriptors (0,4,3) valid at cycle 7 and (1,3,2) at cycle 10; done_o pulse at cycle 11; busy_o low at cycle 12.
- Same table, ready low for 5 cycles at the first ISSUE -> fields stable and valid held for those 5 cycles; schedule shifts by 5; both descriptors delivered in order.
- Table {2,8,1,x} -> exactly one descriptor (0,8,1), then done_o; topo_addr_o never exceeds 2.
- start_i pulsed again while busy -> ignored; only one walk's descriptors appear.
- reset_i high during the second ISSUE -> next edge all outputs 0 and state IDLE; a later start_i replays the full walk from layer 0.
- TOPO_CHECK_EN defined, table {3,4,0,2} -> first descriptor not issued, error_o=1, done_o pulses once; error_o clears on the next accepted start_i.
